// File: rtl/lru_eviction_policy_multiset_if.sv
// Controller-to-policy bundle: hit/allocate updates, victim request and the registered result.
interface lru_eviction_policy_multiset_if #(
    parameter int NUM_WAYS  = 4,
    parameter int SET_WIDTH = 4
);
    logic                 hitValid;
    logic [SET_WIDTH-1:0] hitSet;
    logic [NUM_WAYS-1:0]  hitWay;
    logic                 allocateValid;
    logic [SET_WIDTH-1:0] allocateSet;
    logic [NUM_WAYS-1:0]  allocateWay;
    logic                 evictReq;
    logic [SET_WIDTH-1:0] evictSet;
    logic [NUM_WAYS-1:0]  validMask;
    logic [NUM_WAYS-1:0]  lockMask;
    logic [NUM_WAYS-1:0]  evictionTarget;
    logic                 evictionReady;
    logic                 evictionFail;

    modport master (
        output hitValid, hitSet, hitWay,
        output allocateValid, allocateSet, allocateWay,
        output evictReq, evictSet, validMask, lockMask,
        input  evictionTarget, evictionReady, evictionFail
    );

    modport slave (
        input  hitValid, hitSet, hitWay,
        input  allocateValid, allocateSet, allocateWay,
        input  evictReq, evictSet, validMask, lockMask,
        output evictionTarget, evictionReady, evictionFail
    );
endinterface

// File: rtl/lru_eviction_policy_multiset.sv
// Multi-set true-LRU policy: per-set age permutations, hit/allocate touches,
// victim selection preferring unlocked invalid ways, registered one-hot result.
module lru_eviction_policy_multiset #(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 16,
    parameter int SET_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    parameter int AGE_WIDTH = $clog2(NUM_WAYS)
) (
    input  logic clk,
    input  logic reset,
    lru_eviction_policy_multiset_if.slave bus
);
    typedef logic [NUM_WAYS-1:0][AGE_WIDTH-1:0] ages_t;
    localparam logic [NUM_WAYS-1:0] ONE = {{(NUM_WAYS-1){1'b0}}, 1'b1};

    function automatic logic is_onehot(input logic [NUM_WAYS-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    // Touched way becomes MRU; only ways younger than it age by one.
    function automatic ages_t touch(input ages_t a, input logic [NUM_WAYS-1:0] way);
        logic [AGE_WIDTH-1:0] touched_age;
        ages_t                res;
        touched_age = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way[w]) touched_age = touched_age | a[w];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way[w])                   res[w] = '0;
            else if (a[w] < touched_age)  res[w] = a[w] + 1'b1;
            else                          res[w] = a[w];
        end
        return res;
    endfunction

    ages_t r_age      [NUM_SETS];
    ages_t w_age_hit  [NUM_SETS];
    ages_t w_age_next [NUM_SETS];

    logic w_hit_ok;
    logic w_alloc_ok;
    assign w_hit_ok   = bus.hitValid      && is_onehot(bus.hitWay);
    assign w_alloc_ok = bus.allocateValid && is_onehot(bus.allocateWay);

    // Hit is applied before allocate so a same-set allocate always ends MRU.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
            assign w_age_hit[gi] = (w_hit_ok && bus.hitSet == SET_WIDTH'(gi))
                                 ? touch(r_age[gi], bus.hitWay) : r_age[gi];
            assign w_age_next[gi] = (w_alloc_ok && bus.allocateSet == SET_WIDTH'(gi))
                                  ? touch(w_age_hit[gi], bus.allocateWay) : w_age_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_age[s][w] <= AGE_WIDTH'(w);
                end
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_age[s] <= w_age_next[s];
            end
        end
    end

    ages_t                w_sel_age;
    logic [NUM_WAYS-1:0]  w_cand;
    logic [NUM_WAYS-1:0]  w_invalid;
    logic [NUM_WAYS-1:0]  w_victim;
    logic                 w_fail;
    logic                 w_found;
    logic [AGE_WIDTH-1:0] w_best_age;

    // Selection reads pre-update ages, so same-cycle touches are not visible.
    always_comb begin
        w_sel_age  = r_age[0];
        w_victim   = '0;
        w_fail     = 1'b0;
        w_found    = 1'b0;
        w_best_age = '0;
        for (int s = 0; s < NUM_SETS; s++) begin
            if (bus.evictSet == SET_WIDTH'(s)) w_sel_age = r_age[s];
        end
        w_cand    = ~bus.lockMask;
        w_invalid = w_cand & ~bus.validMask;
        if (w_invalid != '0) begin
            w_victim = w_invalid & (~w_invalid + ONE);
        end else if (w_cand == '0) begin
            w_fail = 1'b1;
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (w_cand[w] && (!w_found || w_sel_age[w] > w_best_age)) begin
                    w_found    = 1'b1;
                    w_best_age = w_sel_age[w];
                    w_victim   = ONE << w;
                end
            end
        end
    end

    logic [NUM_WAYS-1:0] r_target;
    logic                r_ready;
    logic                r_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target <= '0;
            r_ready  <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_ready <= bus.evictReq;
            if (bus.evictReq) begin
                r_target <= w_victim;
                r_fail   <= w_fail;
            end
        end
    end

    assign bus.evictionTarget = r_target;
    assign bus.evictionReady  = r_ready;
    assign bus.evictionFail   = r_fail;
endmodule

// File: tb/tb_lru_eviction_policy_multiset.sv
// Scoreboard bench for the multi-set LRU policy: expected victims are queued at
// request time and compared when the ready pulse arrives.
module tb_lru_eviction_policy_multiset;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lru_eviction_policy_multiset_if #(.NUM_WAYS(4), .SET_WIDTH(4)) bus();

    lru_eviction_policy_multiset #(.NUM_WAYS(4), .NUM_SETS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] target;
        logic       fail;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        if (bus.evictionReady === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_ready: got ready=1 target=%b, required no pulse", bus.evictionTarget);
            end else begin
                e = sb.pop_front();
                if ({bus.evictionTarget, bus.evictionFail} !== {e.target, e.fail}) begin
                    n_fail++;
                    $display("FAIL %s: got target=%b fail=%b, required target=%b fail=%b",
                             e.name, bus.evictionTarget, bus.evictionFail, e.target, e.fail);
                end else begin
                    $display("ok   %s: target=%b fail=%b", e.name, bus.evictionTarget, bus.evictionFail);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hitValid      = 1'b0;
        bus.hitSet        = '0;
        bus.hitWay        = '0;
        bus.allocateValid = 1'b0;
        bus.allocateSet   = '0;
        bus.allocateWay   = '0;
        bus.evictReq      = 1'b0;
        bus.evictSet      = '0;
        bus.validMask     = 4'hF;
        bus.lockMask      = '0;
    endtask

    task automatic request(input logic [3:0] set, input logic [3:0] valid, input logic [3:0] lock,
                           input logic [3:0] exp_target, input logic exp_fail, input string name);
        exp_t e;
        e.target = exp_target;
        e.fail   = exp_fail;
        e.name   = name;
        sb.push_back(e);
        bus.evictReq  = 1'b1;
        bus.evictSet  = set;
        bus.validMask = valid;
        bus.lockMask  = lock;
        step();
        bus.evictReq = 1'b0;
    endtask

    task automatic update(input logic hv, input logic [3:0] hs, input logic [3:0] hw,
                          input logic av, input logic [3:0] as, input logic [3:0] aw);
        bus.hitValid      = hv;
        bus.hitSet        = hs;
        bus.hitWay        = hw;
        bus.allocateValid = av;
        bus.allocateSet   = as;
        bus.allocateWay   = aw;
        step();
        bus.hitValid      = 1'b0;
        bus.allocateValid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.evictionTarget, bus.evictionReady, bus.evictionFail} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got target=%b ready=%b fail=%b, required all 0",
                     bus.evictionTarget, bus.evictionReady, bus.evictionFail);
        end
        repeat (2) step();
        reset = 1'b0;
        request(4'd0, 4'hF, 4'h0, 4'b1000, 1'b0, "reset_lru_set0");
        drain("reset");
    endtask

    task automatic test_hit();
        update(1'b1, 4'd0, 4'b1000, 1'b0, 4'd0, 4'b0000);
        request(4'd0, 4'hF, 4'h0,    4'b0100, 1'b0, "hit_set0");
        request(4'd0, 4'hF, 4'b0100, 4'b0010, 1'b0, "hit_set0_locked");
        drain("hit");
    endtask

    task automatic test_same_cycle();
        exp_t e;
        update(1'b1, 4'd2, 4'b0001, 1'b1, 4'd2, 4'b0010);
        request(4'd2, 4'hF, 4'h0, 4'b1000, 1'b0, "hit_alloc_set2");
        update(1'b1, 4'd2, 4'b1000, 1'b0, 4'd0, 4'b0000);
        request(4'd2, 4'hF, 4'h0,    4'b0100, 1'b0, "set2_after_hit");
        request(4'd2, 4'hF, 4'b0100, 4'b0001, 1'b0, "set2_hit_way_age1");
        request(4'd1, 4'hF, 4'h0,    4'b1000, 1'b0, "set1_untouched");
        update(1'b1, 4'd4, 4'b1000, 1'b1, 4'd5, 4'b0100);
        request(4'd4, 4'hF, 4'h0, 4'b0100, 1'b0, "split_hit_set4");
        request(4'd5, 4'hF, 4'h0, 4'b1000, 1'b0, "split_alloc_set5");
        request(4'd5, 4'hF, 4'b1000, 4'b0010, 1'b0, "split_alloc_set5_locked");
        update(1'b1, 4'd6, 4'b1000, 1'b1, 4'd6, 4'b1000);
        request(4'd6, 4'hF, 4'h0, 4'b0100, 1'b0, "same_way_set6");
        // Request and hit in the same cycle: the request sees the old ages.
        e.target = 4'b1000; e.fail = 1'b0; e.name = "req_with_hit_set8";
        sb.push_back(e);
        bus.hitValid = 1'b1; bus.hitSet = 4'd8; bus.hitWay = 4'b1000;
        bus.evictReq = 1'b1; bus.evictSet = 4'd8; bus.validMask = 4'hF; bus.lockMask = 4'h0;
        step();
        bus.hitValid = 1'b0;
        bus.evictReq = 1'b0;
        request(4'd8, 4'hF, 4'h0, 4'b0100, 1'b0, "set8_after_hit");
        drain("same_cycle");
    endtask

    task automatic test_invalid_lock();
        request(4'd1, 4'b0101, 4'b0010, 4'b1000, 1'b0, "invalid_unlocked");
        drain("invalid");
        n_checks++;
        if ({bus.evictionReady, bus.evictionTarget, bus.evictionFail} !== {1'b0, 4'b1000, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_target: got ready=%b target=%b fail=%b, required 0 1000 0",
                     bus.evictionReady, bus.evictionTarget, bus.evictionFail);
        end
        request(4'd7, 4'b1110, 4'b1001, 4'b0100, 1'b0, "invalid_locked_fallback_age");
        request(4'd7, 4'b0000, 4'b0000, 4'b0001, 1'b0, "all_invalid_lowest");
        request(4'd1, 4'hF,    4'b1111, 4'b0000, 1'b1, "all_locked_fail");
        drain("lock");
        n_checks++;
        if ({bus.evictionReady, bus.evictionTarget, bus.evictionFail} !== {1'b0, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_fail: got ready=%b target=%b fail=%b, required 0 0000 1",
                     bus.evictionReady, bus.evictionTarget, bus.evictionFail);
        end
    endtask

    task automatic test_bad_onehot();
        update(1'b1, 4'd1, 4'b0110, 1'b0, 4'd0, 4'b0000);
        update(1'b1, 4'd1, 4'b0000, 1'b0, 4'd0, 4'b0000);
        update(1'b1, 4'd1, 4'b1100, 1'b1, 4'd1, 4'b1001);
        request(4'd1, 4'hF, 4'h0,    4'b1000, 1'b0, "bad_onehot_lru");
        request(4'd1, 4'hF, 4'b1000, 4'b0100, 1'b0, "bad_onehot_age2");
        request(4'd1, 4'hF, 4'b1100, 4'b0010, 1'b0, "bad_onehot_age1");
        drain("bad_onehot");
    endtask

    task automatic test_back_to_back();
        request(4'd0, 4'hF, 4'h0, 4'b0100, 1'b0, "b2b_set0");
        request(4'd1, 4'hF, 4'h0, 4'b1000, 1'b0, "b2b_set1");
        request(4'd2, 4'hF, 4'h0, 4'b0100, 1'b0, "b2b_set2");
        request(4'd5, 4'hF, 4'h0, 4'b1000, 1'b0, "b2b_set5");
        drain("b2b");
    endtask

    task automatic test_mid_reset();
        update(1'b1, 4'd3, 4'b1000, 1'b0, 4'd0, 4'b0000);
        bus.evictReq = 1'b1; bus.evictSet = 4'd3; bus.validMask = 4'hF; bus.lockMask = 4'h0;
        step();
        bus.evictReq = 1'b0;
        n_checks++;
        if ({bus.evictionReady, bus.evictionTarget} !== {1'b1, 4'b0100}) begin
            n_fail++;
            $display("FAIL pre_reset_result: got ready=%b target=%b, required 1 0100",
                     bus.evictionReady, bus.evictionTarget);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.evictionReady, bus.evictionTarget, bus.evictionFail} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got ready=%b target=%b fail=%b, required all 0",
                     bus.evictionReady, bus.evictionTarget, bus.evictionFail);
        end
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        request(4'd3, 4'hF, 4'h0, 4'b1000, 1'b0, "set3_after_reset");
        request(4'd0, 4'hF, 4'h0, 4'b1000, 1'b0, "set0_after_reset");
        drain("mid_reset");
    endtask

    initial begin
        test_reset();
        test_hit();
        test_same_cycle();
        test_invalid_lock();
        test_bad_onehot();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lru_eviction_policy_multiset.md
# lru_eviction_policy_multiset

Parametrised, multi-set true-LRU eviction policy; next generation of the single-set `EvictionPolicyInterface`/LRU policy pair. It keeps per-set recency state for `NUM_SETS` sets of `NUM_WAYS` ways. It accepts hit and allocate updates from the cache controller and answers one victim request per cycle with a registered one-hot target. New in this generation:
- set indexing
- invalid-way preference
- per-request way locking
- explicit no-victim indication

## Interface
- `NUM_WAYS`, default 4: ways per set; ≥2, power of two.
- `NUM_SETS`, default 16: sets tracked; ≥1, power of two.
- `SET_WIDTH`, default `$clog2(NUM_SETS)` (min 1): set index width.
- `AGE_WIDTH`, default `$clog2(NUM_WAYS)`: per-way age width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `hitValid`  in  1  hit update strobe.
- `hitSet`  in  SET_WIDTH  set of the hit.
- `hitWay`  in  NUM_WAYS  one-hot hit way.
- `allocateValid`  in  1  allocate update strobe.
- `allocateSet`  in  SET_WIDTH  set of the allocation.
- `allocateWay`  in  NUM_WAYS  one-hot allocated way.
- `evictReq`  in  1  victim request strobe.
- `evictSet`  in  SET_WIDTH  set being queried.
- `validMask`  in  NUM_WAYS  per-way valid bits of `evictSet`; sampled with `evictReq`.
- `lockMask`  in  NUM_WAYS  ways that must not be chosen; sampled with `evictReq`.
- `evictionTarget`  out  NUM_WAYS  one-hot victim; all-zero when none.
- `evictionReady`  out  1  one-cycle pulse: result valid.
- `evictionFail`  out  1  qualifies `evictionReady`: no selectable way.

## Operation
- State: `age[set][way]`, AGE_WIDTH bits. Per set, the ages are always a permutation of 0..NUM_WAYS-1. Age 0 = MRU, NUM_WAYS-1 = LRU.
- Reset: `age[s][w] = w` for every set s.
- Touch(set, way w with age a):
  - every way with age < a increments;
  - w becomes 0;
  - ways with age > a are unchanged;
  - the permutation is preserved.
- Hit: touch(`hitSet`, `hitWay`) when `hitValid`=1.
- Allocate: touch(`allocateSet`, `allocateWay`) when `allocateValid`=1.
- Non-one-hot way vector (zero or multiple bits): the update is dropped and state is unchanged.
- Hit and allocate in the same cycle, different sets: both applied independently.
- Hit and allocate in the same cycle, same set, different ways: hit applied first, then allocate. The allocated way ends MRU and the hit way ends age 1.
- Hit and allocate in the same cycle, same set, same way: single touch.
- Victim selection for `evictSet`, candidates = ~`lockMask`:
  1. If any candidate has `validMask`=0: pick the lowest-index such way.
  2. Else pick the candidate with the largest age (unique by construction).
  3. If there are no candidates: target 0, `evictionFail`=1.
- Selection uses ages as they were at the start of the request cycle. Same-cycle hit/allocate updates are not visible to that request.
- Requests are not stalled; the block has no backpressure.

## Timing
- Outputs at reset: `evictionTarget`=0, `evictionReady`=0, `evictionFail`=0.
- Request latency: `evictReq` sampled at edge N. `evictionTarget`/`evictionFail` are registered and valid with `evictionReady`=1 during cycle N+1.
- Throughput: one request per cycle. Back-to-back requests give consecutive ready pulses.
- Between requests: `evictionTarget` and `evictionFail` hold their last value; `evictionReady` is 0.
- Update latency: hit/allocate take effect at the sampling edge. A request in the following cycle sees the new ages.
- Reset asserted mid-operation:
  - all outputs clear immediately (asynchronously);
  - any in-flight result is discarded, with no ready pulse after deassertion;
  - ages return to reset values.
- Inputs in the first cycle after reset deassertion are sampled normally.

## Test plan
- Reset, then `evictReq`, set 0, `validMask`=4'b1111, `lockMask`=0 → next cycle: `evictionReady`=1, `evictionTarget`=4'b1000, `evictionFail`=0.
- Hit set 0 way 4'b1000, then request set 0 → ages [1,2,3,0]; target 4'b0100. Repeat with `lockMask`=4'b0100 → target 4'b0010.
- From reset, same-cycle hit 4'b0001 and allocate 4'b0010 on set 2 → ages [1,0,2,3]; request target 4'b1000. Then hit 4'b1000 → target 4'b0100. Set 1 still returns 4'b1000.
- `validMask`=4'b0101, `lockMask`=4'b0010 → target 4'b1000 (lowest unlocked invalid way). `lockMask`=4'b1111 → target 0, `evictionFail`=1.
- `hitWay`=4'b0110 or 4'b0000 with `hitValid`=1 → no state change; next request on that set is unchanged. Back-to-back requests on sets 0,1,2 → three consecutive ready pulses with correct per-set targets.
- After a hit on set 3, assert `reset` in the cycle after `evictReq` → `evictionReady`/`evictionTarget` drop to 0 at once, with no pulse after release. Set 3 returns 4'b1000 again.
